life_grid: RTL
==============

# life_grid

Parametrised life-like cellular automaton engine: a ROWS×COLS grid of cells, each updated by programmable birth/survive rules. All cells update in parallel, one generation per clock. It is the successor to the single fixed-rule cell and sits between a host row-loader and a display/readback path. The block adds row-streamed loading, a bounded multi-generation run with a generation counter, and early termination when the grid stops changing.

## Interface
- ROWS, 8, grid height (≥3)
- COLS, 8, grid width (≥3)
- GEN_W, 16, width of generation count/limit
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- load_valid  in  1  row beat valid
- load_ready  out  1  row beat accepted when high with load_valid
- load_row  in  COLS  row data; bit c = column c
- rule_birth  in  9  bit n set: dead cell with n live neighbours is born
- rule_survive  in  9  bit n set: live cell with n live neighbours survives
- start  in  1  begin run (pulse)
- gens  in  GEN_W  generation limit, sampled with start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- stable  out  1  last run ended because the grid was unchanged
- gen_count  out  GEN_W  generations computed in the current/last run
- rd_addr  in  $clog2(ROWS)  readback row select
- rd_row  out  COLS  combinational readback of the current grid row rd_addr

## Operation
- Reset (rst=0 at clk edge): FSM=IDLE, all grid cells 0, row pointer 0, gen_count 0, stable 0, done 0, busy 0, load_ready 1.
- FSM states are IDLE, RUN and DONE.
- IDLE: load_ready=1. Each accepted beat writes load_row to row[row_ptr], then row_ptr increments and wraps from ROWS-1 to 0.
- IDLE with start=1 and load_valid=0: latch gens, rule_birth and rule_survive; clear gen_count and stable; row_ptr→0. If gens==0, go to DONE; otherwise go to RUN.
- IDLE with start and load_valid in the same cycle: the load beat is accepted and start is ignored.
- RUN: load_ready=0 and busy=1. Each cycle, every cell computes its next state:
  - live neighbour count n is 0..8, a 4-bit unsigned value;
  - next = state ? survive[n] : birth[n].
- In RUN the grid is written every cycle and gen_count increments.
- Transition to DONE when gen_count+1 == latched gens, or when the next grid equals the current grid.
  - The unchanged-grid case sets stable=1. The grid is still written, which is a no-op.
  - That generation is counted.
- DONE: done=1 for exactly one cycle, busy=0, then back to IDLE. start is ignored outside IDLE.
- Edge handling: out-of-grid neighbours read as 0 unless LIFE_WRAP_EN is defined (see Configuration).
- Rule latching: changing rule_* mid-run has no effect until the next start.
- Reset mid-run: the grid clears and the FSM returns to IDLE immediately. No done pulse is issued.

## Timing
- Load: 1 row per cycle at full throughput. The written row is visible on rd_row the cycle after acceptance.
- Start→busy: 1 cycle.
- Run latency: busy is high for exactly min(gens, k) cycles, where k is the first generation that produces no change. done follows in the next cycle.
- stable and gen_count hold their values from DONE until the next accepted start.
- rd_row is combinational from the grid registers. During RUN it shows the current generation.

## Configuration
- LIFE_WRAP_EN defined: toroidal grid.
  - Row −1 maps to ROWS-1 and row ROWS maps to 0; columns wrap the same way.
- LIFE_WRAP_EN undefined: bounded grid with a dead border.

## Structure
- Package life_pkg holds:
  - FSM state enum: IDLE, RUN, DONE;
  - rule mask typedef logic [8:0];
  - constants for the Conway rule: B3 = 9'b000001000, S23 = 9'b000001100.
- Sub-module life_rule_cell, instantiated ROWS×COLS times:
  - inputs: current state, 8 neighbour bits, latched birth/survive masks;
  - output: next state;
  - contents: combinational popcount plus mask lookup.
- The top level owns the grid registers, row loader, FSM and the change detect, which is a wide OR of next^current.

## Test plan
- Blinker: 8×8 Conway rule, row 3 = 0b00011100, gens=1 → row 2,3,4 = 0b00001000 each; gen_count=1, stable=0, done after 2 cycles.
- Block (2×2 still life), gens=10 → ends after gen 1 with stable=1, gen_count=1, grid unchanged.
- Glider, 8×8, gens=4, with LIFE_WRAP_EN → pattern shifted by (+1,+1). Near the edge without LIFE_WRAP_EN, a glider at the corner decays to a 2×2 block; check exact grid against the golden model.
- gens=0 start → done asserts the cycle after start, busy never goes high, gen_count=0.
- Custom rule B36/S23 (HighLife), replicator seed, gens=12 → matches the software model bit-exactly. Changing rule_birth mid-run does not alter the result.
- rst=0 asserted in the 3rd RUN cycle → next cycle: all rd_row=0, busy=0, load_ready=1, no done. start together with load_valid → beat written, busy stays 0.

Source files
------------

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared types and constants for the life_grid cellular
//                automaton: FSM state encoding, rule mask type, Conway rule
//                masks and a neighbour popcount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    // Run controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit n of a rule mask applies to a cell with n live neighbours
    typedef logic [8:0] rule_t;

    // Conway's Game of Life: born on 3, survives on 2 or 3
    localparam rule_t B3  = 9'b000001000;
    localparam rule_t S23 = 9'b000001100;

    // Number of set bits among the eight neighbours (0..8)
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage : life_pkg
`default_nettype wire

// File: rtl/life_rule_cell.sv
`default_nettype none
// ============================================================================
//  Module      : life_rule_cell
//  Description : Next-state logic for one cell: counts live neighbours and
//                looks the count up in the birth or survive mask depending
//                on the cell's current state. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_rule_cell
    import life_pkg::*;
(
    input  logic       state,
    input  logic [7:0] nbrs,
    input  rule_t      birth,
    input  rule_t      survive,
    output logic       next_state
);

    logic [3:0] live_cnt;

    // Popcount then mask lookup; a count of 0..8 always indexes inside the mask
    always_comb begin
        live_cnt   = popcount8(nbrs);
        next_state = state ? survive[live_cnt] : birth[live_cnt];
    end

endmodule : life_rule_cell
`default_nettype wire

// File: rtl/life_grid.sv
`default_nettype none
// ============================================================================
//  Module      : life_grid
//  Description : ROWS x COLS life-like cellular automaton. Rows are streamed
//                in while idle; a start pulse launches a run of up to 'gens'
//                generations (one per clock) which ends early once the grid
//                stops changing. Grid is readable one row at a time.
//  Build macro : LIFE_WRAP_EN - when defined the grid is toroidal, otherwise
//                cells outside the grid read as dead.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_grid
    import life_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [COLS-1:0]         load_row,
    input  logic [8:0]              rule_birth,
    input  logic [8:0]              rule_survive,
    input  logic                    start,
    input  logic [GEN_W-1:0]        gens,
    output logic                    busy,
    output logic                    done,
    output logic                    stable,
    output logic [GEN_W-1:0]        gen_count,
    input  logic [$clog2(ROWS)-1:0] rd_addr,
    output logic [COLS-1:0]         rd_row
);

    localparam int              RW       = $clog2(ROWS);
    localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);

    state_t                     state_q,     state_d;
    logic [ROWS-1:0][COLS-1:0]  grid_q,      grid_d;
    logic [RW-1:0]              row_ptr_q,   row_ptr_d;
    logic [GEN_W-1:0]           gens_q,      gens_d;
    logic [GEN_W-1:0]           gen_count_q, gen_count_d;
    rule_t                      birth_q,     birth_d;
    rule_t                      survive_q,   survive_d;
    logic                       stable_q,    stable_d;

    logic [ROWS+1:0][COLS+1:0]  pad;
    logic [ROWS-1:0][COLS-1:0]  next_grid;
    logic                       changed;
    logic [GEN_W-1:0]           gen_inc;

    // Grid surrounded by a one-cell halo: dead border, or wrapped copies of the
    // opposite edges. Corners come straight from the grid so the halo never
    // reads itself.
    always_comb begin
        pad = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pad[r+1][c+1] = grid_q[r][c];
            end
        end
`ifdef LIFE_WRAP_EN
        for (int c = 0; c < COLS; c++) begin
            pad[0][c+1]      = grid_q[ROWS-1][c];
            pad[ROWS+1][c+1] = grid_q[0][c];
        end
        for (int r = 0; r < ROWS; r++) begin
            pad[r+1][0]      = grid_q[r][COLS-1];
            pad[r+1][COLS+1] = grid_q[r][0];
        end
        pad[0][0]           = grid_q[ROWS-1][COLS-1];
        pad[0][COLS+1]      = grid_q[ROWS-1][0];
        pad[ROWS+1][0]      = grid_q[0][COLS-1];
        pad[ROWS+1][COLS+1] = grid_q[0][0];
`endif
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            life_rule_cell u_cell (
                .state      (grid_q[r][c]),
                .nbrs       ({pad[r][c],   pad[r][c+1],   pad[r][c+2],
                              pad[r+1][c],                pad[r+1][c+2],
                              pad[r+2][c], pad[r+2][c+1], pad[r+2][c+2]}),
                .birth      (birth_q),
                .survive    (survive_q),
                .next_state (next_grid[r][c])
            );
        end
    end

    assign changed = |(next_grid ^ grid_q);
    assign gen_inc = gen_count_q + 1'b1;

    // Controller: row loading in IDLE, one generation per cycle in RUN,
    // single-cycle completion in DONE
    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        row_ptr_d   = row_ptr_q;
        gens_d      = gens_q;
        gen_count_d = gen_count_q;
        birth_d     = birth_q;
        survive_d   = survive_q;
        stable_d    = stable_q;
        case (state_q)
            IDLE: begin
                // A load beat takes priority; a coincident start is dropped
                if (load_valid) begin
                    grid_d[row_ptr_q] = load_row;
                    row_ptr_d = (row_ptr_q == LAST_ROW) ? '0 : row_ptr_q + 1'b1;
                end else if (start) begin
                    gens_d      = gens;
                    birth_d     = rule_birth;
                    survive_d   = rule_survive;
                    gen_count_d = '0;
                    stable_d    = 1'b0;
                    row_ptr_d   = '0;
                    state_d     = (gens == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // An unchanged generation is still written and counted
                grid_d      = next_grid;
                gen_count_d = gen_inc;
                if (!changed) begin
                    stable_d = 1'b1;
                end
                if ((gen_inc == gens_q) || !changed) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grid_q      <= '0;
            row_ptr_q   <= '0;
            gens_q      <= '0;
            gen_count_q <= '0;
            birth_q     <= B3;
            survive_q   <= S23;
            stable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            row_ptr_q   <= row_ptr_d;
            gens_q      <= gens_d;
            gen_count_q <= gen_count_d;
            birth_q     <= birth_d;
            survive_q   <= survive_d;
            stable_q    <= stable_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign stable     = stable_q;
    assign gen_count  = gen_count_q;
    assign rd_row     = grid_q[rd_addr];

endmodule : life_grid
`default_nettype wire
